// File: rtl/i2s_dac_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : i2s_dac_tx_if
// Description : PCM pair handshake bundle between the processing datapath
//               (master) and the I2S DAC serializer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface i2s_dac_tx_if #(
    parameter int W = 16
);
    logic [W-1:0] i_left;   // left sample, two's complement
    logic [W-1:0] i_right;  // right sample, two's complement
    logic         i_valid;  // a sample pair is offered
    logic         o_ready;  // serializer can take a pair

    modport master (
        output i_left,
        output i_right,
        output i_valid,
        input  o_ready
    );

    modport slave (
        input  i_left,
        input  i_right,
        input  i_valid,
        output o_ready
    );
endinterface
`default_nettype wire

// File: rtl/i2s_dac_tx.sv
`default_nettype none
// ============================================================================
// Module      : i2s_dac_tx
// Description : Serializes stereo PCM pairs onto the WM8731 DACDAT line in
//               I2S format with the codec as bit/frame clock master. Holds
//               one pending pair behind a valid/ready handshake and counts
//               frames that start with nothing to send.
// Options     : I2S_DAC_TX_HOLD_LAST_EN - when defined, an underrun frame
//               repeats the last transmitted pair instead of sending zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_dac_tx #(
    parameter int W      = 16,
    parameter int UCNT_W = 8
) (
    input  wire                i_clk,
    input  wire                i_rst,
    input  wire                i_daclrck,
    i2s_dac_tx_if.slave        pcm,
    output logic               o_dacdat,
    output logic               o_frame_start,
    output logic [UCNT_W-1:0]  o_underrun_cnt
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_BCNT_W = (W > 2) ? $clog2(W) : 1;

    localparam logic [c_BCNT_W-1:0] c_BCNT_LAST = c_BCNT_W'(W - 1);
    localparam logic [UCNT_W-1:0]   c_UCNT_MAX  = '1;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_SHIFT_L = 3'd1;
    localparam logic [2:0] c_ST_PAD_L   = 3'd2;
    localparam logic [2:0] c_ST_SHIFT_R = 3'd3;
    localparam logic [2:0] c_ST_PAD_R   = 3'd4;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic                r_lrck_d;
    logic                w_fe;
    logic                w_re;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;

    logic                r_pend_v;
    logic [W-1:0]        r_pend_l;
    logic [W-1:0]        r_pend_r;

    logic [W-1:0]        r_sh_l;
    logic [W-1:0]        r_sh_r;
    logic [W-1:0]        r_hold_r;
    logic [c_BCNT_W-1:0] r_bcnt;

    logic                r_dacdat;
    logic                r_frame_start;
    logic [UCNT_W-1:0]   r_ucnt;

    logic                w_ready;
    logic                w_accept;
    logic                w_bypass;
    logic                w_underrun;
    logic [W-1:0]        w_load_l;
    logic [W-1:0]        w_load_r;

    logic                w_frame_load;
    logic                w_right_load;
    logic                w_shift_l;
    logic                w_shift_r;
    logic                w_dacdat_nxt;

`ifdef I2S_DAC_TX_HOLD_LAST_EN
    logic [W-1:0]        r_last_l;
    logic [W-1:0]        r_last_r;
`endif

    // ------------------------------------------------------------------
    // LRCK edge detection
    // ------------------------------------------------------------------
    // Track LRCK every cycle, reset included, so releasing reset never
    // presents a stale level as an edge.
    always_ff @(posedge i_clk) begin
        r_lrck_d <= i_daclrck;
    end

    assign w_fe = r_lrck_d & ~i_daclrck;
    assign w_re = ~r_lrck_d & i_daclrck;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign w_ready     = ~r_pend_v & ~i_rst;
    assign pcm.o_ready = w_ready;
    assign w_accept    = pcm.i_valid & w_ready;

    // A pair offered in the very cycle a frame is loaded with nothing
    // pending goes straight into the shifter instead of the pending slot.
    assign w_bypass    = w_frame_load & ~r_pend_v & pcm.i_valid;

    // Select the pair a frame-load would use: pending, bypass, or underrun fill.
    always_comb begin
        w_load_l   = '0;
        w_load_r   = '0;
        w_underrun = 1'b0;
        if (r_pend_v) begin
            w_load_l = r_pend_l;
            w_load_r = r_pend_r;
        end else if (pcm.i_valid) begin
            w_load_l = pcm.i_left;
            w_load_r = pcm.i_right;
        end else begin
            w_underrun = 1'b1;
`ifdef I2S_DAC_TX_HOLD_LAST_EN
            w_load_l   = r_last_l;
            w_load_r   = r_last_r;
`endif
        end
    end

    // Pending slot: filled on a non-bypass accept, drained by a frame-load.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend_v <= 1'b0;
            r_pend_l <= '0;
            r_pend_r <= '0;
        end else if (w_frame_load && r_pend_v) begin
            r_pend_v <= 1'b0;
        end else if (w_accept && !w_bypass) begin
            r_pend_v <= 1'b1;
            r_pend_l <= pcm.i_left;
            r_pend_r <= pcm.i_right;
        end
    end

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle datapath controls; the next DACDAT bit is
    // chosen here so the pin stays a plain register.
    always_comb begin
        w_state_nxt  = r_state;
        w_frame_load = 1'b0;
        w_right_load = 1'b0;
        w_shift_l    = 1'b0;
        w_shift_r    = 1'b0;
        w_dacdat_nxt = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_fe) begin
                    w_frame_load = 1'b1;
                    w_dacdat_nxt = w_load_l[W-1];
                    w_state_nxt  = c_ST_SHIFT_L;
                end
            end
            c_ST_SHIFT_L: begin
                // An early RE abandons the rest of the left word.
                if (w_re) begin
                    w_right_load = 1'b1;
                    w_dacdat_nxt = r_hold_r[W-1];
                    w_state_nxt  = c_ST_SHIFT_R;
                end else if (r_bcnt != '0) begin
                    w_shift_l    = 1'b1;
                    w_dacdat_nxt = r_sh_l[W-1];
                end else begin
                    w_state_nxt  = c_ST_PAD_L;
                end
            end
            c_ST_PAD_L: begin
                if (w_re) begin
                    w_right_load = 1'b1;
                    w_dacdat_nxt = r_hold_r[W-1];
                    w_state_nxt  = c_ST_SHIFT_R;
                end
            end
            c_ST_SHIFT_R: begin
                // An early FE abandons the rest of the right word.
                if (w_fe) begin
                    w_frame_load = 1'b1;
                    w_dacdat_nxt = w_load_l[W-1];
                    w_state_nxt  = c_ST_SHIFT_L;
                end else if (r_bcnt != '0) begin
                    w_shift_r    = 1'b1;
                    w_dacdat_nxt = r_sh_r[W-1];
                end else begin
                    w_state_nxt  = c_ST_PAD_R;
                end
            end
            c_ST_PAD_R: begin
                if (w_fe) begin
                    w_frame_load = 1'b1;
                    w_dacdat_nxt = w_load_l[W-1];
                    w_state_nxt  = c_ST_SHIFT_L;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shift datapath
    // ------------------------------------------------------------------
    // The MSB leaves through r_dacdat in the load cycle, so the shifters
    // keep only the remaining bits and r_bcnt counts how many are left.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sh_l   <= '0;
            r_sh_r   <= '0;
            r_hold_r <= '0;
            r_bcnt   <= '0;
        end else if (w_frame_load) begin
            r_sh_l   <= {w_load_l[W-2:0], 1'b0};
            r_hold_r <= w_load_r;
            r_bcnt   <= c_BCNT_LAST;
        end else if (w_right_load) begin
            r_sh_r   <= {r_hold_r[W-2:0], 1'b0};
            r_bcnt   <= c_BCNT_LAST;
        end else if (w_shift_l) begin
            r_sh_l   <= {r_sh_l[W-2:0], 1'b0};
            r_bcnt   <= r_bcnt - 1'b1;
        end else if (w_shift_r) begin
            r_sh_r   <= {r_sh_r[W-2:0], 1'b0};
            r_bcnt   <= r_bcnt - 1'b1;
        end
    end

    // Registered serial output and frame-start marker.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dacdat      <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_dacdat      <= w_dacdat_nxt;
            r_frame_start <= w_frame_load;
        end
    end

    // Saturating count of frames that found neither a pending nor an offered pair.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ucnt <= '0;
        end else if (w_frame_load && w_underrun && (r_ucnt != c_UCNT_MAX)) begin
            r_ucnt <= r_ucnt + 1'b1;
        end
    end

`ifdef I2S_DAC_TX_HOLD_LAST_EN
    // Remember the pair each frame started with; an underrun reloads it unchanged.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_l <= '0;
            r_last_r <= '0;
        end else if (w_frame_load) begin
            r_last_l <= w_load_l;
            r_last_r <= w_load_r;
        end
    end
`endif

    assign o_dacdat       = r_dacdat;
    assign o_frame_start  = r_frame_start;
    assign o_underrun_cnt = r_ucnt;

endmodule
`default_nettype wire

// File: tb/tb_i2s_dac_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_dac_tx
// Description : Scoreboard bench for i2s_dac_tx. A frame-level reference
//               model schedules the expected DACDAT bit stream per LRCK
//               half-frame; a monitor compares every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_dac_tx;

    localparam int W      = 16;
    localparam int UCNT_W = 8;

    logic              clk     = 1'b0;
    logic              rst     = 1'b1;
    logic              daclrck = 1'b1;
    logic              dacdat;
    logic              frame_start;
    logic [UCNT_W-1:0] ucnt;

    i2s_dac_tx_if #(.W(W)) pcm_bus ();

    i2s_dac_tx #(
        .W      (W),
        .UCNT_W (UCNT_W)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_daclrck      (daclrck),
        .pcm            (pcm_bus),
        .o_dacdat       (dacdat),
        .o_frame_start  (frame_start),
        .o_underrun_cnt (ucnt)
    );

    initial forever #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model (frame level)
    // ------------------------------------------------------------------
    typedef struct {
        bit          dac;
        bit          fs;
        int unsigned ucnt;
        bit          rdy;
    } exp_t;

    exp_t         sbq[$];
    bit           m_sched[$];   // expected DACDAT from the next cycle onward
    bit [W-1:0]   m_pend_l[$];
    bit [W-1:0]   m_pend_r[$];
    bit           m_lrck_prev = 1'b1;
    bit           m_active    = 1'b0;   // a frame has begun since reset
    bit           m_chan      = 1'b0;   // 0 left half, 1 right half
    bit           m_fs        = 1'b0;
    int unsigned  m_ucnt      = 0;
    bit [W-1:0]   m_hold_r    = '0;
    bit [W-1:0]   m_last_l    = '0;
    bit [W-1:0]   m_last_r    = '0;
    bit           m_acc       = 1'b0;

    function automatic void sched_word(input bit [W-1:0] word);
        m_sched.delete();
        for (int i = W - 1; i >= 0; i--) m_sched.push_back(word[i]);
    endfunction

    // One bit-clock cycle of the model with the inputs present in it.
    function automatic void model(input bit r, input bit lr, input bit v,
                                  input bit [W-1:0] l, input bit [W-1:0] rr);
        exp_t       e;
        bit         rdy, fe, re, fl, byp;
        bit [W-1:0] pl, pr;
        rdy    = !r && (m_pend_l.size() == 0);
        e.dac  = (m_sched.size() > 0) ? m_sched.pop_front() : 1'b0;
        e.fs   = m_fs;
        e.ucnt = m_ucnt;
        e.rdy  = rdy;
        sbq.push_back(e);
        m_acc = v && rdy;
        m_fs  = 1'b0;
        if (r) begin
            m_sched.delete();
            m_pend_l.delete();
            m_pend_r.delete();
            m_ucnt = 0; m_active = 1'b0; m_chan = 1'b0;
            m_last_l = '0; m_last_r = '0;
            m_lrck_prev = lr;
            return;
        end
        fe = m_lrck_prev && !lr;
        re = !m_lrck_prev && lr;
        m_lrck_prev = lr;
        fl  = fe && (!m_active || m_chan);
        byp = 1'b0;
        if (fl) begin
            if (m_pend_l.size() > 0) begin
                pl = m_pend_l.pop_front();
                pr = m_pend_r.pop_front();
            end else if (v) begin
                pl = l; pr = rr; byp = 1'b1;
            end else begin
`ifdef I2S_DAC_TX_HOLD_LAST_EN
                pl = m_last_l; pr = m_last_r;
`else
                pl = '0; pr = '0;
`endif
                if (m_ucnt < (2 ** UCNT_W) - 1) m_ucnt++;
            end
            m_last_l = pl; m_last_r = pr; m_hold_r = pr;
            sched_word(pl);
            m_active = 1'b1; m_chan = 1'b0; m_fs = 1'b1;
        end else if (re && m_active && !m_chan) begin
            sched_word(m_hold_r);
            m_chan = 1'b1;
        end
        if (m_acc && !byp) begin
            m_pend_l.push_back(l);
            m_pend_r.push_back(rr);
        end
    endfunction

    // ------------------------------------------------------------------
    // Monitor: one scoreboard entry per cycle, sampled mid-cycle
    // ------------------------------------------------------------------
    exp_t mon_e;
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            chk("dacdat",      {31'd0, dacdat},              {31'd0, mon_e.dac});
            chk("frame_start", {31'd0, frame_start},         {31'd0, mon_e.fs});
            chk("underrun_cnt", {{(32-UCNT_W){1'b0}}, ucnt}, mon_e.ucnt);
            chk("ready",       {31'd0, pcm_bus.o_ready},     {31'd0, mon_e.rdy});
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int         vmode = 0;     // 0 idle, 1 offer once, 2 random with vprob
    int         vprob = 0;
    bit [W-1:0] cur_l = '0;
    bit [W-1:0] cur_r = '0;

    task automatic step(input bit r, input bit lr, input bit v,
                        input bit [W-1:0] l, input bit [W-1:0] rr);
        @(posedge clk);
        #1;
        rst             = r;
        daclrck         = lr;
        pcm_bus.i_valid = v;
        pcm_bus.i_left  = l;
        pcm_bus.i_right = rr;
        model(r, lr, v, l, rr);
    endtask

    task automatic half(input bit lvl, input int len);
        bit v;
        for (int i = 0; i < len; i++) begin
            case (vmode)
                1:       v = 1'b1;
                2:       v = ($urandom_range(99) < vprob);
                default: v = 1'b0;
            endcase
            step(1'b0, lvl, v, cur_l, cur_r);
            if (m_acc) begin
                if (vmode == 1) vmode = 0;
                cur_l = W'($urandom);
                cur_r = W'($urandom);
            end
        end
    endtask

    task automatic frame(input int len_l, input int len_r);
        half(1'b0, len_l);
        half(1'b1, len_r);
    endtask

    initial begin
        pcm_bus.i_valid = 1'b0;
        pcm_bus.i_left  = '0;
        pcm_bus.i_right = '0;

        // Reset with LRCK high.
        repeat (3) step(1'b1, 1'b1, 1'b0, '0, '0);

        // Known pair offered before the first FE, 32-cycle half-frames.
        cur_l = 16'hA5C3; cur_r = 16'h0F0F; vmode = 1;
        half(1'b1, 3);
        frame(32, 32);

        // Three frames with nothing offered.
        vmode = 0;
        repeat (3) frame(32, 32);
        @(negedge clk);
        chk("underrun_after_3", {{(32-UCNT_W){1'b0}}, ucnt}, 32'd3);

        // Known pair, then three underrun frames (repeat or zeros by build).
        cur_l = 16'h8001; cur_r = 16'h7FFE; vmode = 1;
        frame(32, 32);
        vmode = 0;
        repeat (3) frame(32, 32);

        // Valid held high continuously.
        vmode = 2; vprob = 100;
        repeat (4) frame(32, 32);

        // Drain, then a pair offered only in the FE cycle (bypass).
        vmode = 0;
        frame(32, 32);
        cur_l = W'($urandom); cur_r = W'($urandom);
        step(1'b0, 1'b0, 1'b1, cur_l, cur_r);
        half(1'b0, 31);
        half(1'b1, 32);
        @(negedge clk);
        chk("underrun_after_bypass", {{(32-UCNT_W){1'b0}}, ucnt}, 32'd6);

        // Short left half-frame, then a normal frame.
        vmode = 2; vprob = 100;
        frame(8, 32);
        frame(32, 32);

        // Reset in the middle of the right word, released with LRCK low.
        vmode = 0;
        half(1'b0, 32);
        half(1'b1, 4);
        repeat (2) step(1'b1, 1'b1, 1'b0, '0, '0);
        repeat (2) step(1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("dacdat_after_reset", {31'd0, dacdat}, 32'd0);
        chk("underrun_after_reset", {{(32-UCNT_W){1'b0}}, ucnt}, 32'd0);
        vmode = 2; vprob = 60;
        half(1'b0, 19);
        half(1'b1, 32);
        frame(32, 32);

        // Random half-frame lengths and offer rates.
        for (int f = 0; f < 20; f++) begin
            int ll, lr;
            ll = ($urandom_range(7) == 0) ? $urandom_range(16, 8) : $urandom_range(40, 17);
            lr = ($urandom_range(7) == 0) ? $urandom_range(16, 8) : $urandom_range(40, 17);
            vmode = 2; vprob = $urandom_range(100);
            frame(ll, lr);
        end

        vmode = 0;
        half(1'b1, 2);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", sbq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
